phase_seq: RTL and testbench

Multicycle phase sequencer and instruction register for the five-phase core. Generates the one-hot `phase` vector (f, r, x, m, w) consumed by the `pc` register and the datapath. Runs the instruction-memory fetch handshake at the current `pc` and the optional data-memory handshake in the m phase. Holds the fetched instruction stable in `ir` for the rest of the instruction.

---
 rtl/phase_seq_if.sv | 39 +++
 rtl/phase_seq.sv | 179 +++++++++++++++++
 tb/tb_phase_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/phase_seq_if.sv
// ---------------------------------------------------------------------------
// phase_seq_if
//   Memory-side handshake bundle for the phase sequencer.
//
//   imem_req   : instruction read request (sequencer -> imem)
//   imem_addr  : instruction address      (sequencer -> imem)
//   imem_rdata : instruction word         (imem -> sequencer)
//   imem_ack   : instruction read done    (imem -> sequencer)
//   dmem_req   : data access request      (sequencer -> dmem)
//   dmem_ack   : data access done         (dmem -> sequencer)
//
//   master : the sequencer side.  slave : the memory side.
// ---------------------------------------------------------------------------
interface phase_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/phase_seq.sv
// ---------------------------------------------------------------------------
// phase_seq
//   Multicycle phase sequencer and instruction register for the five-phase
//   core. Steps IDLE -> FWAIT -> F -> R -> X -> M -> W -> (FWAIT | HALT),
//   runs the instruction fetch handshake in FWAIT and the optional data
//   handshake in M, and holds the fetched word in ir for the whole
//   instruction.
//
//   Parameters
//     TIMEOUT   : max wait cycles on one handshake (timeout build only)
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     pc        : current program counter, forwarded as imem_addr
//     phase     : one-hot {w, m, x, r, f}; zero in IDLE/FWAIT/HALT
//     mem       : memory handshake bundle (phase_seq_if.master)
//     ir        : latched instruction word
//     dmem_need : current instruction accesses data memory (used in M)
//     halt      : current instruction is a halt (used in W)
//     halted    : sequencer stopped
//     err       : handshake timeout, sticky until rst
//
//   Build option
//     PHASE_SEQ_TIMEOUT_EN : when defined, an 8-bit wait counter bounds
//     each handshake to TIMEOUT cycles; on expiry the sequencer halts with
//     err set. When undefined, waits are unbounded and err is 0.
// ---------------------------------------------------------------------------
module phase_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    output logic [4:0]         phase,
    phase_seq_if.master        mem,
    output logic [31:0]        ir,
    input  logic               dmem_need,
    input  logic               halt,
    output logic               halted,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWAIT,
        S_F,
        S_R,
        S_X,
        S_M,
        S_W,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;

`ifdef PHASE_SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        ir_d    = ir_q;
`ifdef PHASE_SEQ_TIMEOUT_EN
        err_d      = err_q;
        // Counter is zero outside a wait, so it is already clear on entry
        // to FWAIT or M.
        wait_cnt_d = 8'd0;
`endif

        unique case (state_q)
            S_IDLE: state_d = S_FWAIT;

            S_FWAIT: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    state_d = S_F;
                end
`ifdef PHASE_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            S_F: state_d = S_R;
            S_R: state_d = S_X;
            S_X: state_d = S_M;

            S_M: begin
                if (!dmem_need || mem.dmem_ack) begin
                    state_d = S_W;
                end
`ifdef PHASE_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            S_W: state_d = halt ? S_HALT : S_FWAIT;

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
`ifdef PHASE_SEQ_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
`ifdef PHASE_SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (from registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        phase = 5'b00000;
        unique case (state_q)
            S_F:     phase = 5'b00001;
            S_R:     phase = 5'b00010;
            S_X:     phase = 5'b00100;
            S_M:     phase = 5'b01000;
            S_W:     phase = 5'b10000;
            default: phase = 5'b00000;
        endcase
    end

    assign mem.imem_req  = (state_q == S_FWAIT);
    assign mem.imem_addr = pc;
    // dmem_need comes from the decoder off the stable ir, so gating the
    // request with it only shapes the M state, it never glitches the phase.
    assign mem.dmem_req  = (state_q == S_M) && dmem_need;
    assign halted        = (state_q == S_HALT);
    assign ir            = ir_q;

`ifdef PHASE_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
    // TIMEOUT only matters in the timeout build.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// ---------------------------------------------------------------------------
// tb_phase_seq
//   Self-checking bench for phase_seq. A per-cycle schedule of stimulus and
//   expected outputs is built up front from the instruction-level rules
//   (wait counts, need/halt flags, reset points), then played against the
//   DUT. Acks arriving while a request is low are randomized to prove they
//   are ignored.
// ---------------------------------------------------------------------------
module tb_phase_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [4:0]  phase;
    logic [31:0] ir;
    logic        dmem_need;
    logic        halt;
    logic        halted;
    logic        err;

    phase_seq_if mem_if ();

    phase_seq #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .phase     (phase),
        .mem       (mem_if),
        .ir        (ir),
        .dmem_need (dmem_need),
        .halt      (halt),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One schedule entry: inputs driven during the cycle and the outputs
    // the DUT must show in that cycle.
    typedef struct {
        bit          rst;
        bit          iack;
        logic [31:0] rdata;
        bit          dack;
        bit          need;
        bit          halt;
        logic [31:0] pc;
        logic [4:0]  ph;
        bit          ireq;
        bit          dreq;
        logic [31:0] ir;
        bit          hlt;
        bit          err;
    } cyc_t;

    cyc_t        sched[$];
    logic [31:0] m_pc = 32'h0000_1000;
    logic [31:0] m_ir = 32'd0;

    // Background cycle: junk on every input that should not matter.
    function automatic cyc_t junk();
        cyc_t c;
        c.rst   = 1'b0;
        c.iack  = 1'($urandom);
        c.rdata = $urandom;
        c.dack  = 1'($urandom);
        c.need  = 1'($urandom);
        c.halt  = 1'($urandom);
        c.pc    = m_pc;
        c.ph    = 5'd0;
        c.ireq  = 1'b0;
        c.dreq  = 1'b0;
        c.ir    = m_ir;
        c.hlt   = 1'b0;
        c.err   = 1'b0;
        return c;
    endfunction

    // First cycle out of reset.
    task automatic add_idle(input bit late_dack);
        cyc_t c;
        c = junk();
        if (late_dack) c.dack = 1'b1;
        sched.push_back(c);
    endtask

    // n halted cycles, the last one asserting rst, then the IDLE cycle.
    task automatic add_halt_then_reset(input int n, input bit err_exp);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c      = junk();
            c.hlt  = 1'b1;
            c.err  = err_exp;
            c.rst  = (i == n - 1);
            sched.push_back(c);
        end
        m_ir = 32'd0;
        add_idle(1'b0);
    endtask

    // One instruction: iw fetch wait cycles, word, dmem need with dw wait
    // cycles, halt flag. rst_m >= 0 asserts rst in that M cycle instead of
    // finishing the instruction.
    task automatic add_instr(input int iw, input logic [31:0] word, input bit need,
                             input int dw, input bit hlt, input int rst_m);
        cyc_t c;
        int   m_len;
        for (int i = 0; i <= iw; i++) begin
            c       = junk();
            c.iack  = (i == iw);
            if (i == iw) c.rdata = word;
            c.ireq  = 1'b1;
            sched.push_back(c);
        end
        m_ir = word;
        c = junk(); c.ph = 5'b00001; sched.push_back(c);
        m_pc = m_pc + 32'd4;
        c = junk(); c.ph = 5'b00010; sched.push_back(c);
        c = junk(); c.ph = 5'b00100; sched.push_back(c);
        m_len = need ? dw + 1 : 1;
        for (int j = 0; j < m_len; j++) begin
            c      = junk();
            c.ph   = 5'b01000;
            c.need = need;
            c.dreq = need;
            if (need) c.dack = (j == dw);
            if (j == rst_m) begin
                c.dack = 1'b0;
                c.rst  = 1'b1;
                sched.push_back(c);
                m_ir = 32'd0;
                add_idle(1'b1);
                return;
            end
            sched.push_back(c);
        end
        c = junk(); c.ph = 5'b10000; c.halt = hlt; sched.push_back(c);
        if (hlt) add_halt_then_reset(21, 1'b0);
    endtask

    initial begin
        cyc_t c;

        rst               = 1'b1;
        pc                = 32'd0;
        dmem_need         = 1'b0;
        halt              = 1'b0;
        mem_if.imem_ack   = 1'b0;
        mem_if.imem_rdata = 32'd0;
        mem_if.dmem_ack   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_phase",  32'(phase),           32'd0);
        check("rst_ireq",   32'(mem_if.imem_req), 32'd0);
        check("rst_dreq",   32'(mem_if.dmem_req), 32'd0);
        check("rst_ir",     ir,                   32'd0);
        check("rst_halted", 32'(halted),          32'd0);
        check("rst_err",    32'(err),             32'd0);

        // Zero-wait instructions, then a delayed fetch, then a dmem wait.
        add_idle(1'b0);
        add_instr(0, 32'h1234_5678, 1'b0, 0, 1'b0, -1);
        add_instr(0, 32'h1234_5678, 1'b0, 0, 1'b0, -1);
        add_instr(3, $urandom, 1'b0, 0, 1'b0, -1);
        add_instr(0, $urandom, 1'b1, 2, 1'b0, -1);
        for (int n = 0; n < 30; n++)
            add_instr($urandom_range(0, 3), $urandom, 1'($urandom),
                      $urandom_range(0, 3), 1'b0, -1);
        // Halt, 20 idle halted cycles, reset restart.
        add_instr($urandom_range(0, 2), $urandom, 1'b0, 0, 1'b1, -1);
        // Reset during a pending data access; late ack must be ignored.
        add_instr(0, $urandom, 1'b1, 5, 1'b0, 1);
        for (int n = 0; n < 10; n++)
            add_instr($urandom_range(0, 3), $urandom, 1'($urandom),
                      $urandom_range(0, 3), 1'b0, -1);
        add_instr(1, $urandom, 1'b0, 0, 1'b1, -1);
`ifdef PHASE_SEQ_TIMEOUT_EN
        // Fetch never acked: four wait cycles, then HALT with err.
        for (int i = 0; i < 4; i++) begin
            c      = junk();
            c.iack = 1'b0;
            c.ireq = 1'b1;
            sched.push_back(c);
        end
        for (int i = 0; i < 5; i++) begin
            c     = junk();
            c.hlt = 1'b1;
            c.err = 1'b1;
            sched.push_back(c);
        end
`endif

        foreach (sched[k]) begin
            c                 = sched[k];
            rst               = c.rst;
            pc                = c.pc;
            dmem_need         = c.need;
            halt              = c.halt;
            mem_if.imem_ack   = c.iack;
            mem_if.imem_rdata = c.rdata;
            mem_if.dmem_ack   = c.dack;
            #1;
            check($sformatf("phase@%0d", k),  32'(phase),           32'(c.ph));
            check($sformatf("ireq@%0d", k),   32'(mem_if.imem_req), 32'(c.ireq));
            check($sformatf("dreq@%0d", k),   32'(mem_if.dmem_req), 32'(c.dreq));
            check($sformatf("iaddr@%0d", k),  mem_if.imem_addr,     c.pc);
            check($sformatf("ir@%0d", k),     ir,                   c.ir);
            check($sformatf("halted@%0d", k), 32'(halted),          32'(c.hlt));
            check($sformatf("err@%0d", k),    32'(err),             32'(c.err));
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
